case_conv_buffer: RTL and testbench

Sits directly downstream of the UART receiver: consumes each received byte, applies a selectable ASCII case conversion, buffers the result in a small FIFO and launches it into the UART transmitter one byte at a time with a start/busy handshake. Decouples receive bursts from transmit pacing and reports overflow drops.

---
 rtl/case_conv_pkg.sv | 47 ++++
 rtl/case_conv_buffer_fifo.sv | 69 ++++++
 rtl/case_conv_buffer.sv | 151 +++++++++++++++
 tb/tb_case_conv_buffer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/case_conv_pkg.sv
// case_conv_pkg
//   Shared definitions for case_conv_buffer: case-conversion mode encodings,
//   launch FSM state enum, ASCII constants and the byte conversion function.
//   No ports (package).
package case_conv_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_UPPER  = 2'b01,
    MODE_LOWER  = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_LAUNCH    = 2'b01,
    S_WAIT_ACK  = 2'b10,
    S_WAIT_DONE = 2'b11
  } state_e;

  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_UC_A     = 8'h41;
  localparam logic [7:0] ASCII_UC_Z     = 8'h5A;
  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  // Letters are the only bytes ever altered; everything else passes
  // unchanged whatever the mode.
  function automatic logic [7:0] conv_byte(input logic [7:0] b, input logic [1:0] mode);
    logic       is_upper;
    logic       is_lower;
    logic [7:0] r;
    is_upper = (b >= ASCII_UC_A) && (b <= ASCII_UC_Z);
    is_lower = (b >= ASCII_LC_A) && (b <= ASCII_LC_Z);
    r = b;
    case (mode)
      MODE_UPPER:  if (is_lower) r = b - ASCII_CASE_BIT;
      MODE_LOWER:  if (is_upper) r = b + ASCII_CASE_BIT;
      MODE_TOGGLE: if (is_upper || is_lower) r = b ^ ASCII_CASE_BIT;
      default:     r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/case_conv_buffer_fifo.sv
// sync_fifo
//   Single-clock FIFO with asynchronous active-low reset on the pointers and
//   occupancy. Supports one or two writes per cycle (the second entry lands
//   at the slot after the first) and one read per cycle. The caller is
//   responsible for never overfilling or reading empty.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wr_en               write wr_data (and wr_data2 when wr_dual)
//   wr_dual             write two entries this cycle
//   wr_data, wr_data2   first / second write entry
//   rd_en               advance read pointer
//   rd_data             head entry (combinational read)
//   count               occupancy, 0..DEPTH
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic                       wr_dual,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [WIDTH-1:0]           wr_data2,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr_p1;
  logic [CW-1:0]    wr_num;
  logic [CW-1:0]    rd_num;

  assign wr_ptr_p1 = wr_ptr + AW'(1);
  assign rd_data   = mem[rd_ptr];

  always_comb begin
    wr_num = '0;
    if (wr_en) wr_num = wr_dual ? CW'(2) : CW'(1);
    rd_num = {{(CW-1){1'b0}}, rd_en};
  end

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      if (wr_dual) mem[wr_ptr_p1] <= wr_data2;
    end
  end

  // Pointers are exactly AW bits wide so they wrap at DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_dual ? (wr_ptr + AW'(2)) : wr_ptr_p1;
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + wr_num - rd_num;
    end
  end

endmodule

// File: rtl/case_conv_buffer.sv
// case_conv_buffer
//   Receives bytes from a UART receiver, applies an ASCII case conversion,
//   buffers them in a FIFO and launches them one at a time into a UART
//   transmitter with a start/busy handshake. Counts dropped bytes.
//   Optional feature macro: CASE_CONV_CRLF_EN -- a received 0x0D is stored
//   as the pair 0x0D,0x0A in a single cycle (needs two free entries).
//
//   Handshake: a byte is offered to the transmitter by a one-cycle tx_start
//   pulse with tx_data valid in the same cycle; the transmitter acknowledges
//   by raising tx_busy and releases the launcher by dropping it. If tx_busy
//   never rises within ACK_TIMEOUT cycles the byte is treated as sent.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   rx_data      received byte, valid while rx_valid high
//   rx_valid     byte valid (rising edge pushes once)
//   mode         00 pass, 01 upper, 10 lower, 11 toggle (sampled at push)
//   tx_busy      transmitter busy
//   tx_start     one-cycle launch pulse
//   tx_data      registered launched byte
//   fifo_count   FIFO occupancy
//   overflow     one-cycle pulse per dropped input byte
//   drop_count   saturating dropped-byte counter
module case_conv_buffer
  import case_conv_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic [1:0]                    mode,
  input  logic                          tx_busy,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [7:0]                    drop_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e        state;
  state_e        state_next;
  logic [TW-1:0] timer;
  logic          rx_valid_q;
  logic          push_edge;
  logic          pop;
  logic          room1;
  logic          accept;
  logic          drop;
  logic          wr_dual;
  logic [7:0]    conv_data;
  logic [7:0]    head;
  logic          load_data;

  assign push_edge = rx_valid & ~rx_valid_q;
  assign conv_data = conv_byte(rx_data, mode);
  assign pop       = (state == S_LAUNCH);

  // A pop in the same cycle frees the slot it reads, so a full FIFO can
  // still take a byte while launching.
  assign room1 = (fifo_count != CW'(FIFO_DEPTH)) || pop;

`ifdef CASE_CONV_CRLF_EN
  logic is_cr;
  logic room2;
  assign is_cr   = (rx_data == ASCII_CR);
  assign room2   = (fifo_count <= CW'(FIFO_DEPTH - 2)) ||
                   (pop && (fifo_count <= CW'(FIFO_DEPTH - 1)));
  assign wr_dual = is_cr;
  assign accept  = push_edge & (is_cr ? room2 : room1);
`else
  assign wr_dual = 1'b0;
  assign accept  = push_edge & room1;
`endif

  assign drop = push_edge & ~accept;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept),
    .wr_dual  (wr_dual),
    .wr_data  (conv_data),
    .wr_data2 (ASCII_LF),
    .rd_en    (pop),
    .rd_data  (head),
    .count    (fifo_count)
  );

  // rx_valid_q resets high so a level held through reset does not push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b1;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      rx_valid_q <= rx_valid;
      overflow   <= drop;
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      timer   <= '0;
      tx_data <= '0;
    end else begin
      state <= state_next;
      if (state == S_WAIT_ACK) timer <= timer + TW'(1);
      else                     timer <= '0;
      // Captured on entry to LAUNCH so tx_data is already valid during the
      // tx_start cycle and holds until the next launch.
      if (load_data) tx_data <= head;
    end
  end

  always_comb begin
    state_next = state;
    load_data  = 1'b0;
    tx_start   = 1'b0;
    case (state)
      S_IDLE: begin
        if ((fifo_count != '0) && !tx_busy) begin
          state_next = S_LAUNCH;
          load_data  = 1'b1;
        end
      end
      S_LAUNCH: begin
        tx_start   = 1'b1;
        state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy)                                state_next = S_WAIT_DONE;
        else if (timer == TW'(ACK_TIMEOUT - 1))     state_next = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_case_conv_buffer.sv
// tb_case_conv_buffer
//   Directed and randomized bench for case_conv_buffer. A transmitter model
//   answers tx_start with a configurable busy period (or forced/never busy);
//   a monitor compares every launched byte with an expected queue built from
//   the case-conversion rules.
module tb_case_conv_buffer;

  localparam int DEPTH = 16;
  localparam int ACK_T = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam int TX_NORMAL = 0;
  localparam int TX_FORCE  = 1;
  localparam int TX_NONE   = 2;

`ifdef CASE_CONV_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  localparam logic [7:0] CH_UA = "A";
  localparam logic [7:0] CH_UZ = "Z";
  localparam logic [7:0] CH_LA = "a";
  localparam logic [7:0] CH_LZ = "z";

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          tx_busy = 1'b0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [7:0]    drop_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int start_cyc[$];
  int tx_mode = TX_NORMAL;
  int busy_len = 3;
  int busy_cnt = 0;
  int starts = 0;
  int ovf_seen = 0;
  int cyc = 0;
  int fill = 0;
  int exp_drops = 0;

  case_conv_buffer #(
    .FIFO_DEPTH  (DEPTH),
    .ACK_TIMEOUT (ACK_T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .mode       (mode),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  // ---------------- clock / watchdog ----------------
  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference conversion straight from the letter-range rules.
  function automatic logic [7:0] ref_conv(input logic [7:0] b, input logic [1:0] m);
    bit up;
    bit lo;
    up = (b >= CH_UA) && (b <= CH_UZ);
    lo = (b >= CH_LA) && (b <= CH_LZ);
    case (m)
      2'd1:    return lo ? b - 8'd32 : b;
      2'd2:    return up ? b + 8'd32 : b;
      2'd3:    return up ? b + 8'd32 : (lo ? b - 8'd32 : b);
      default: return b;
    endcase
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    if ($urandom_range(0, 1) == 1) begin
      b = ($urandom_range(0, 1) == 1) ? CH_UA : CH_LA;
      b = b + 8'($urandom_range(0, 25));
    end else begin
      b = 8'($urandom_range(0, 255));
    end
    if (b == 8'h0D) b = 8'h2E;
    return b;
  endfunction

  // ---------------- transmitter model ----------------
  initial forever begin
    @(negedge clk);
    if (!rst_n) busy_cnt = 0;
    else if (tx_start === 1'b1 && tx_mode == TX_NORMAL) busy_cnt = busy_len;
    case (tx_mode)
      TX_FORCE: tx_busy = 1'b1;
      TX_NONE:  tx_busy = 1'b0;
      default: begin
        tx_busy = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
      end
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    logic [7:0] exp_b;
    @(negedge clk);
    if (tx_start === 1'b1) begin
      starts++;
      start_cyc.push_back(cyc);
      check("start_has_expected_byte", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        check("tx_data", tx_data, exp_b);
      end
    end
    if (overflow === 1'b1) ovf_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b, input logic [1:0] m);
    int need;
    @(negedge clk);
    rx_data  = b;
    mode     = m;
    rx_valid = 1'b1;
    need = (CRLF && b == 8'h0D) ? 2 : 1;
    if (tx_mode != TX_FORCE || fill + need <= DEPTH) begin
      fill += need;
      exp_q.push_back(ref_conv(b, m));
      if (need == 2) exp_q.push_back(8'h0A);
    end else begin
      exp_drops++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_count !== '0 || tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_within_budget", n < budget, 1);
    repeat (ACK_T + 5) @(negedge clk);
  endtask

  task automatic force_busy();
    tx_mode = TX_FORCE;
    fill = 0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s0;
    int o0;
    int n;
    int gap;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // latency: count at N+1, tx_start at N+2
    @(negedge clk);
    rx_data = 8'h61; mode = 2'b00; rx_valid = 1'b1;
    exp_q.push_back(ref_conv(8'h61, 2'b00));
    @(negedge clk);
    rx_valid = 1'b0;
    check("lat_count_n1", fifo_count, 1);
    check("lat_no_start_n1", tx_start, 0);
    @(negedge clk);
    check("lat_start_n2", tx_start, 1);
    wait_drain(200);

    // upper "aZ9"
    busy_len = 10;
    s0 = starts;
    push_byte(8'h61, 2'b01);
    push_byte(8'h5A, 2'b01);
    push_byte(8'h39, 2'b01);
    wait_drain(300);
    check("upper_starts", starts - s0, 3);

    // toggle
    s0 = starts;
    push_byte(8'h41, 2'b11);
    push_byte(8'h7B, 2'b11);
    wait_drain(300);
    check("toggle_starts", starts - s0, 2);

    // held rx_valid pushes once
    s0 = starts;
    @(negedge clk);
    rx_data = 8'h62; mode = 2'b00; rx_valid = 1'b1;
    exp_q.push_back(ref_conv(8'h62, 2'b00));
    repeat (20) @(negedge clk);
    rx_valid = 1'b0;
    wait_drain(300);
    check("held_single_start", starts - s0, 1);

    // random bursts
    for (int b = 0; b < 6; b++) begin
      busy_len = $urandom_range(1, 10);
      n = $urandom_range(1, 12);
      s0 = starts;
      for (int i = 0; i < n; i++) begin
        push_byte(rand_byte(), 2'($urandom_range(0, 3)));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain(1000);
      check("burst_starts", starts - s0, n);
    end

    // carriage return handling
`ifdef CASE_CONV_CRLF_EN
    busy_len = 3;
    force_busy();
    o0 = ovf_seen;
    for (int i = 0; i < DEPTH - 1; i++) push_byte(rand_byte(), 2'b00);
    push_byte(8'h0D, 2'b00);
    repeat (3) @(negedge clk);
    check("crlf_full_count", fifo_count, DEPTH - 1);
    check("crlf_full_ovf", ovf_seen - o0, 1);
    check("crlf_full_drops", drop_count, exp_drops);
    tx_mode = TX_NORMAL;
    wait_drain(1000);
    s0 = starts;
    push_byte(8'h0D, 2'b01);
    wait_drain(300);
    check("crlf_pair_starts", starts - s0, 2);
`else
    busy_len = 3;
    s0 = starts;
    push_byte(8'h0D, 2'b01);
    wait_drain(300);
    check("cr_plain_starts", starts - s0, 1);
`endif

    // ack timeout: transmitter never answers
    tx_mode = TX_NONE;
    repeat (2) @(negedge clk);
    start_cyc.delete();
    push_byte(rand_byte(), 2'b00);
    push_byte(rand_byte(), 2'b10);
    wait_drain(300);
    check("ack_to_starts", start_cyc.size(), 2);
    if (start_cyc.size() == 2) begin
      gap = start_cyc[1] - start_cyc[0];
      check("ack_to_gap_in_range", (gap >= ACK_T + 1) && (gap <= ACK_T + 3), 1);
    end
    tx_mode = TX_NORMAL;
    repeat (2) @(negedge clk);

    // overflow and drop_count saturation
    force_busy();
    o0 = ovf_seen;
    for (int i = 0; i < DEPTH + 3; i++) push_byte(rand_byte(), 2'($urandom_range(0, 3)));
    repeat (3) @(negedge clk);
    check("ovf_count_full", fifo_count, DEPTH);
    check("ovf_pulses", ovf_seen - o0, 3);
    check("ovf_drop_count", drop_count, exp_drops);
    for (int i = 0; i < 260; i++) push_byte(rand_byte(), 2'b00);
    repeat (3) @(negedge clk);
    check("sat_drop_count", drop_count, (exp_drops > 255) ? 255 : exp_drops);
    check("sat_ovf_pulses", ovf_seen - o0, 263);
    check("sat_count_full", fifo_count, DEPTH);
    busy_len = 4;
    tx_mode = TX_NORMAL;
    wait_drain(2000);

    // reset during WAIT_DONE with rx_valid held across reset
    busy_len = 40;
    s0 = starts;
    push_byte(8'h7A, 2'b01);
    n = 0;
    while (starts == s0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_launched", starts - s0, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    rx_data = 8'h55;
    rx_valid = 1'b1;
    #1;
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_fifo_count", fifo_count, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_drop_count", drop_count, 0);
    exp_drops = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s0 = starts;
    repeat (10) @(negedge clk);
    check("held_through_rst_count", fifo_count, 0);
    check("held_through_rst_starts", starts - s0, 0);
    rx_valid = 1'b0;
    busy_len = 3;
    repeat (2) @(negedge clk);
    s0 = starts;
    push_byte(rand_byte(), 2'($urandom_range(0, 3)));
    wait_drain(300);
    check("post_rst_starts", starts - s0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
